// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_e   - fetch FSM states
//   DEFAULT_BITS    - default address / instruction width
//   DEFAULT_TIMEOUT - default number of cycles to wait for a memory response
package fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } fetch_state_e;

   localparam int DEFAULT_BITS    = 32;
   localparam int DEFAULT_TIMEOUT = 255;

endpackage : fetch_pkg

// File: rtl/fetch_timer.sv
// fetch_timer: response wait counter for the fetch unit.
//   clk     - clock
//   rst     - asynchronous active-high reset, clears the count
//   clear   - zero the count (takes priority over enable)
//   enable  - count one cycle spent waiting
//   expired - the current waiting cycle is the TIMEOUT-th one
module fetch_timer
   import fetch_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // The count holds the number of waiting cycles already completed, so
   // the TIMEOUT-th cycle is the one where the count reads TIMEOUT-1.
   assign expired = (count_q >= CNT_W'(TIMEOUT - 1));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : fetch_timer

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//   clk, rst            - clock, asynchronous active-high reset
//   pc                  - fetch address from the program counter
//   stall               - holds the program counter while high
//   hold                - decode not ready (backpressure)
//   instr, instr_valid  - fetched word and its valid flag
//   fault               - sticky fetch fault (misaligned pc, bus error, timeout)
//   imem_req_*          - read request handshake and address
//   imem_rsp_*          - read response valid, data and bus error
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int BITS    = DEFAULT_BITS,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] pc,
   output logic            stall,
   input  logic            hold,
   output logic [BITS-1:0] instr,
   output logic            instr_valid,
   output logic            fault,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [BITS-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [BITS-1:0] imem_rsp_data,
   input  logic            imem_rsp_err
);

   fetch_state_e    state_q, state_d;
   logic [BITS-1:0] instr_q, instr_d;
   logic            instr_valid_q, instr_valid_d;
   logic            fault_q, fault_d;

   logic            pc_aligned;
   logic            req_active;
   logic            timer_expired;

   assign pc_aligned = (pc[1:0] == 2'b00);

   // The program counter advances on the same edge that enters REQ, so the
   // request is decoded from the live pc rather than a registered copy.
   // A misaligned pc never raises a request; the FSM leaves for FAULT.
   assign req_active     = (state_q == S_REQ) && pc_aligned;
   assign imem_req_valid = req_active;
   assign imem_addr      = req_active ? pc : '0;

   assign stall       = !((state_q == S_DONE) && !hold);
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign fault       = fault_q;

   fetch_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (req_active && imem_req_ready),
      .enable (state_q == S_WAIT),
      .expired(timer_expired)
   );

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (!pc_aligned) begin
               state_d = S_FAULT;
            end else if (imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response in the last allowed cycle still wins over the timeout.
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  state_d = S_FAULT;
               end else begin
                  instr_d = imem_rsp_data;
                  state_d = S_DONE;
               end
            end else if (timer_expired) begin
               state_d = S_FAULT;
            end
         end
         S_DONE: begin
            if (!hold) begin
               state_d = S_REQ;
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
      instr_valid_d = (state_d == S_DONE);
      fault_d       = (state_d == S_FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed, table-driven bench for instr_fetch (TIMEOUT=8).
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0;
   logic        stall;
   logic        hold = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fault;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   instr_fetch #(
      .BITS   (32),
      .TIMEOUT(8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc            (pc),
      .stall         (stall),
      .hold          (hold),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .fault         (fault),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr     (imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .imem_rsp_err  (imem_rsp_err)
   );

   typedef struct {
      logic [31:0] pc;
      logic        hold, rdy, rv, err;
      logic [31:0] data;
      logic        e_stall, e_iv, e_fault, e_rv;
      logic [31:0] e_addr, e_instr;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_stall, input logic e_iv,
                             input logic e_fault, input logic e_rv,
                             input logic [31:0] e_addr, input logic [31:0] e_instr);
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
      chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_iv});
      chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e_fault});
      chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
      chk({tag, ".addr"}, imem_addr, e_addr);
      chk({tag, ".instr"}, instr, e_instr);
   endtask

   // Called at a falling edge: drive inputs, check 1 ns later, then move to
   // the next falling edge (the rising edge in between advances the DUT).
   task automatic cycle(input string tag, input logic [31:0] p, input logic h,
                        input logic rdy, input logic rv, input logic err,
                        input logic [31:0] d, input logic e_stall, input logic e_iv,
                        input logic e_fault, input logic e_rv,
                        input logic [31:0] e_addr, input logic [31:0] e_instr);
      pc = p; hold = h; imem_req_ready = rdy;
      imem_rsp_valid = rv; imem_rsp_err = err; imem_rsp_data = d;
      #1;
      $display("%s pc=%08h hold=%b rdy=%b rsp=%b err=%b | stall=%b iv=%b fault=%b req=%b addr=%08h instr=%08h",
               tag, p, h, rdy, rv, err, stall, instr_valid, fault, imem_req_valid, imem_addr, instr);
      check_outs(tag, e_stall, e_iv, e_fault, e_rv, e_addr, e_instr);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pc = '0; hold = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; imem_rsp_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //          pc        hold rdy  rv   err  data          stall iv  flt  rv   addr      instr
      vecs[0]  = '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      vecs[1]  = '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
      vecs[2]  = '{32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2402000A, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
      vecs[3]  = '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2402000A};
      vecs[4]  = '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2402000A};
      vecs[5]  = '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2402000A};
      vecs[6]  = '{32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2402000A};
      vecs[7]  = '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h2402000A};
      vecs[8]  = '{32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h2402000A};
      vecs[9]  = '{32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h2402000A};
      vecs[10] = '{32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11112222, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2402000A};
      vecs[11] = '{32'h4, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h11112222};
      vecs[12] = '{32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h11112222};

      // Zero-wait fetches, decode backpressure, stray response in REQ.
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 13; i++) begin
         cycle($sformatf("vec%0d", i), vecs[i].pc, vecs[i].hold, vecs[i].rdy, vecs[i].rv,
               vecs[i].err, vecs[i].data, vecs[i].e_stall, vecs[i].e_iv, vecs[i].e_fault,
               vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_instr);
      end

      // Slow acceptance at pc=0x40, then no response until timeout.
      do_reset();
      cycle("slow.idle", 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++)
         cycle($sformatf("slow.req%0d", i), 32'h40, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h40, 32'h0);
      cycle("slow.accept", 32'h40, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h40, 32'h0);
      for (int i = 1; i <= 8; i++)
         cycle($sformatf("tmo.wait%0d", i), 32'h40, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("tmo.fault", 32'h40, 0, 1, 1, 0, 32'h55, 1, 0, 1, 0, 32'h0, 32'h0);
      cycle("tmo.sticky", 32'h40, 0, 1, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0);

      // Misaligned pc: no request, fault next cycle and stays.
      do_reset();
      cycle("mis.idle", 32'h6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("mis.req", 32'h6, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++)
         cycle($sformatf("mis.fault%0d", i), 32'h6, 0, 1, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0);

      // Bus error response.
      do_reset();
      cycle("err.idle", 32'h10, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("err.req", 32'h10, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h10, 32'h0);
      cycle("err.wait", 32'h10, 0, 1, 1, 1, 32'hAAAA, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("err.fault", 32'h10, 0, 1, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0);

      // Reset pulsed during WAIT, late response arrives in IDLE.
      do_reset();
      cycle("rw.idle", 32'h20, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("rw.req", 32'h20, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h20, 32'h0);
      cycle("rw.wait", 32'h20, 0, 1, 1, 0, 32'h13, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("rw.done", 32'h20, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h0, 32'h13);
      cycle("rw.req2", 32'h24, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h24, 32'h13);
      cycle("rw.wait2", 32'h24, 0, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h13);
      #3 rst = 1'b1;
      #1;
      $display("rw.async rst=1 | stall=%b iv=%b fault=%b req=%b addr=%08h instr=%08h",
               stall, instr_valid, fault, imem_req_valid, imem_addr, instr);
      check_outs("rw.async", 1, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cycle("rw.late", 32'h0, 0, 1, 1, 0, 32'hBAD, 1, 0, 0, 0, 32'h0, 32'h0);
      cycle("rw.fresh", 32'h0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter BITS, default 32, SHALL set the address and instruction width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent waiting for a memory response.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port pc  input  BITS  SHALL be the current fetch address from the program counter.
REQ-006 Port stall  output  1  SHALL hold the program counter when high.
REQ-007 Port hold  input  1  SHALL be the downstream backpressure (decode not ready).
REQ-008 Port instr  output  BITS  SHALL be the fetched instruction word.
REQ-009 Port instr_valid  output  1  SHALL mark instr as valid for the current pc.
REQ-010 Port fault  output  1  SHALL be a sticky fetch-fault flag.
REQ-011 Port imem_req_valid  output  1  SHALL request a memory read.
REQ-012 Port imem_req_ready  input  1  SHALL be the memory's acceptance of the request.
REQ-013 Port imem_addr  output  BITS  SHALL be the read address.
REQ-014 Port imem_rsp_valid  input  1  SHALL mark imem_rsp_data and imem_rsp_err as valid.
REQ-015 Port imem_rsp_data  input  BITS  SHALL be the read data.
REQ-016 Port imem_rsp_err  input  1  SHALL flag a bus error on the response.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT, DONE and FAULT.
REQ-018 IDLE SHALL go to REQ on the first clock edge after reset deasserts.
REQ-019 On entering REQ, if pc[1:0] != 0, the FSM SHALL go to FAULT without asserting imem_req_valid.
REQ-020 In REQ, imem_req_valid SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_req_ready; on valid&&ready the FSM SHALL go to WAIT.
REQ-021 imem_addr SHALL be 0 and imem_req_valid SHALL be 0 outside REQ.
REQ-022 In WAIT, on imem_rsp_valid with imem_rsp_err=0, instr SHALL register imem_rsp_data and the FSM SHALL go to DONE.
REQ-023 In WAIT, imem_rsp_valid with imem_rsp_err=1 SHALL send the FSM to FAULT.
REQ-024 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle; if it reaches TIMEOUT without a response, the FSM SHALL go to FAULT.
REQ-025 instr_valid SHALL be 1 exactly in DONE.
REQ-026 stall SHALL be 0 only when in DONE and hold=0; otherwise stall SHALL be 1.
REQ-027 In DONE with hold=0, the FSM SHALL go to REQ; the program counter advances on the same edge.
REQ-028 In DONE with hold=1, the FSM SHALL stay in DONE with instr unchanged.
REQ-029 Minimum throughput SHALL be one instruction per 3 cycles (REQ accepted, response, DONE).
REQ-030 imem_rsp_valid outside WAIT SHALL be ignored.
REQ-031 FAULT SHALL be sticky until reset, with fault=1, stall=1 and instr_valid=0.

Reset
REQ-032 Asserting rst SHALL force, asynchronously: state IDLE, instr=0, instr_valid=0, fault=0, stall=1, imem_req_valid=0, wait counter=0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; a late response after reset SHALL be ignored per REQ-030.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum, the default BITS and the default TIMEOUT.
REQ-035 The wait counter SHALL be sub-module fetch_timer (clear, enable, expired); all other logic SHALL stay in instr_fetch.

Verification
REQ-036 Zero-wait memory (ready=1, response one cycle after accept), pc=0 -> request addr 0x0, instr_valid on the third cycle after reset release, stall low for that one cycle.
REQ-037 hold=1 for 4 cycles while in DONE with instr=0x2402000A -> instr_valid and stall=1 held for 4 cycles with instr stable, then stall=0 for one cycle.
REQ-038 imem_req_ready low for 5 cycles at pc=0x40 -> imem_addr=0x40 and imem_req_valid=1 for 6 cycles, then WAIT.
REQ-039 pc=0x6 -> no request issued, fault=1 on the next cycle and remaining high.
REQ-040 No response with TIMEOUT=8 -> fault=1 after 8 WAIT cycles; imem_rsp_err=1 -> fault=1 on the next cycle.
REQ-041 rst pulsed during WAIT, then a response arrives in IDLE -> response ignored, all outputs at reset values, fresh request to pc=0.
